float_byte_assembler: RTL and testbench

Upstream stage of the float comparator. Collects a byte stream four bytes at a time into 32-bit IEEE-754 single-precision words and presents each word on a valid/ready output that drives the comparator's `a` input. It registers sign/zero/NaN classification flags alongside each word. Partial words that stall longer than a programmable gap are discarded.

---
 rtl/float_byte_assembler.sv | 117 +++++++++++
 tb/tb_float_byte_assembler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_byte_assembler.sv
// Packs a byte stream into 32-bit IEEE-754 words with sign/zero/NaN flags.
// Stalled partial words are dropped after a programmable idle gap.
module float_byte_assembler #(
    parameter bit          BIG_ENDIAN     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] a,
    output logic        a_valid,
    input  logic        a_ready,
    output logic        is_neg,
    output logic        is_zero,
    output logic        is_nan,
    output logic        timeout_err,
    output logic [1:0]  byte_count
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [23:0] asm_q, asm_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] idle_q, idle_d;
    logic [31:0] a_q, a_d;
    logic        av_q, av_d;
    logic        neg_q, neg_d;
    logic        zero_q, zero_d;
    logic        nan_q, nan_d;
    logic        tout_q, tout_d;

    logic        accept;
    logic        complete;
    logic [31:0] word;

    assign byte_ready = !av_q || a_ready;
    assign accept     = byte_valid && byte_ready;
    assign complete   = accept && (cnt_q == 2'd3);

    // Only three bytes are ever held; the fourth joins straight from the input.
    assign word = BIG_ENDIAN ? {asm_q, byte_in} : {byte_in, asm_q};

    always_comb begin
        asm_d  = asm_q;
        cnt_d  = cnt_q;
        idle_d = idle_q;
        a_d    = a_q;
        av_d   = av_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        nan_d  = nan_q;
        tout_d = 1'b0;

        if (accept) begin
            asm_d  = BIG_ENDIAN ? {asm_q[15:0], byte_in}
                                : {byte_in, asm_q[23:8]};
            idle_d = '0;
            cnt_d  = cnt_q + 2'd1;
        end else if (cnt_q != 2'd0) begin
            if (TO_EN && idle_q == TO_LAST) begin
                cnt_d  = '0;
                idle_d = '0;
                tout_d = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end else begin
            idle_d = '0;
        end

        if (complete) begin
            a_d    = word;
            av_d   = 1'b1;
            neg_d  = word[31];
            zero_d = (word[30:0] == 31'd0);
            nan_d  = (&word[30:23]) && (|word[22:0]);
        end else if (av_q && a_ready) begin
            av_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asm_q  <= '0;
            cnt_q  <= '0;
            idle_q <= '0;
            a_q    <= '0;
            av_q   <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            nan_q  <= 1'b0;
            tout_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            a_q    <= a_d;
            av_q   <= av_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
            nan_q  <= nan_d;
            tout_q <= tout_d;
        end
    end

    assign a           = a_q;
    assign a_valid     = av_q;
    assign is_neg      = neg_q;
    assign is_zero     = zero_q;
    assign is_nan      = nan_q;
    assign timeout_err = tout_q;
    assign byte_count  = cnt_q;

endmodule

// File: tb/tb_float_byte_assembler.sv
// Bench for float_byte_assembler: big- and little-endian instances share
// one byte stream and are checked against a queue-based model every cycle.
module tb_float_byte_assembler;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        a_ready = 1'b1;

    logic        be_ready, le_ready;
    logic [31:0] be_a, le_a;
    logic        be_av, le_av;
    logic        be_neg, le_neg, be_zero, le_zero, be_nan, le_nan;
    logic        be_to, le_to;
    logic [1:0]  be_cnt, le_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    float_byte_assembler #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(TMO)) u_be (
        .clock(clock), .reset(reset), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(be_ready), .a(be_a),
        .a_valid(be_av), .a_ready(a_ready), .is_neg(be_neg),
        .is_zero(be_zero), .is_nan(be_nan), .timeout_err(be_to),
        .byte_count(be_cnt)
    );

    float_byte_assembler #(.BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(TMO)) u_le (
        .clock(clock), .reset(reset), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(le_ready), .a(le_a),
        .a_valid(le_av), .a_ready(a_ready), .is_neg(le_neg),
        .is_zero(le_zero), .is_nan(le_nan), .timeout_err(le_to),
        .byte_count(le_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Float classification from plain arithmetic on the word value.
    function automatic bit f_neg(input longint unsigned w);
        return w >= 64'h8000_0000;
    endfunction
    function automatic bit f_zero(input longint unsigned w);
        return (w % 64'h8000_0000) == 0;
    endfunction
    function automatic bit f_nan(input longint unsigned w);
        return ((w / 64'h80_0000) % 256) == 255 && (w % 64'h80_0000) != 0;
    endfunction

    // Reference model
    int unsigned mq[$];
    bit          mv = 1'b0;
    bit          mto = 1'b0;
    int          idle = 0;
    logic [31:0] mbe = '0, mle = '0;
    bit          model_ok = 1'b0;
    bit          m_rdy, m_acc;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            mv = 1'b0; mto = 1'b0; idle = 0;
            mbe = '0; mle = '0;
            model_ok = 1'b1;
        end else begin
            m_rdy = !mv || a_ready;
            m_acc = byte_valid && m_rdy;
            mto = 1'b0;
            if (mv && a_ready) mv = 1'b0;
            if (m_acc) begin
                mq.push_back(int'(byte_in));
                idle = 0;
                if (mq.size() == 4) begin
                    mbe = 32'(mq[0] * 32'h100_0000 + mq[1] * 32'h1_0000
                              + mq[2] * 32'h100 + mq[3]);
                    mle = 32'(mq[3] * 32'h100_0000 + mq[2] * 32'h1_0000
                              + mq[1] * 32'h100 + mq[0]);
                    mq.delete();
                    mv = 1'b1;
                end
            end else if (mq.size() != 0) begin
                if (idle + 1 == TMO) begin
                    mq.delete();
                    idle = 0;
                    mto = 1'b1;
                end else begin
                    idle++;
                end
            end else begin
                idle = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok && !reset) begin
            chk("be_a_valid", 32'(be_av), 32'(mv));
            chk("le_a_valid", 32'(le_av), 32'(mv));
            chk("byte_ready", 32'(be_ready), 32'(!mv || a_ready));
            chk("le_byte_ready", 32'(le_ready), 32'(!mv || a_ready));
            chk("byte_count", 32'(be_cnt), 32'(mq.size()));
            chk("le_byte_count", 32'(le_cnt), 32'(mq.size()));
            chk("timeout_err", 32'(be_to), 32'(mto));
            chk("le_timeout_err", 32'(le_to), 32'(mto));
            if (mv) begin
                chk("be_a", be_a, mbe);
                chk("le_a", le_a, mle);
                chk("be_is_neg", 32'(be_neg), 32'(f_neg(64'(mbe))));
                chk("be_is_zero", 32'(be_zero), 32'(f_zero(64'(mbe))));
                chk("be_is_nan", 32'(be_nan), 32'(f_nan(64'(mbe))));
                chk("le_is_neg", 32'(le_neg), 32'(f_neg(64'(mle))));
                chk("le_is_zero", 32'(le_zero), 32'(f_zero(64'(mle))));
                chk("le_is_nan", 32'(le_nan), 32'(f_nan(64'(mle))));
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] b,
                         input logic r);
        byte_valid = v;
        byte_in    = b;
        a_ready    = r;
        @(posedge clock);
        #1;
    endtask

    task automatic send4(input logic [31:0] w, input logic r);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, w[31-8*i -: 8], r);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_a"}, be_a, 32'h0);
        chk({tag, "_a_valid"}, 32'(be_av), 32'h0);
        chk({tag, "_byte_count"}, 32'(be_cnt), 32'h0);
        chk({tag, "_timeout_err"}, 32'(be_to), 32'h0);
        chk({tag, "_flags"}, {29'd0, be_neg, be_zero, be_nan}, 32'h0);
        chk({tag, "_byte_ready"}, 32'(be_ready), 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        reset_checks("reset");
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);

        // Single word, ready high
        drive(1'b1, 8'hBE, 1'b1);
        drive(1'b1, 8'h20, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        chk("t1_no_early_valid", 32'(be_av), 32'h0);
        drive(1'b1, 8'h00, 1'b1);
        chk("t1_a", be_a, 32'hBE20_0000);
        chk("t1_valid", 32'(be_av), 32'h1);
        chk("t1_flags", {29'd0, be_neg, be_zero, be_nan}, 32'h4);
        chk("t1_le_a", le_a, 32'h0000_20BE);
        drive(1'b0, 8'h00, 1'b1);
        chk("t1_valid_drop", 32'(be_av), 32'h0);

        // Back-to-back NaN, -0, +inf
        send4(32'h7FC0_0000, 1'b1);
        chk("t2_w1_a", be_a, 32'h7FC0_0000);
        chk("t2_w1_nan", 32'(be_nan), 32'h1);
        send4(32'h8000_0000, 1'b1);
        chk("t2_w2_valid", 32'(be_av), 32'h1);
        chk("t2_w2_zero_neg", {30'd0, be_zero, be_neg}, 32'h3);
        send4(32'h7F80_0000, 1'b1);
        chk("t2_w3_valid", 32'(be_av), 32'h1);
        chk("t2_w3_inf", {30'd0, be_nan, be_zero}, 32'h0);
        drive(1'b0, 8'h00, 1'b1);

        // Little-endian ordering
        send4(32'h0000_20BE, 1'b1);
        chk("t3_le_a", le_a, 32'hBE20_0000);
        chk("t3_le_neg", 32'(le_neg), 32'h1);
        drive(1'b0, 8'h00, 1'b1);

        // Backpressure
        send4(32'h3F80_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h11, 1'b0);
            chk("t4_hold_a", be_a, 32'h3F80_0000);
            chk("t4_blocked", 32'(be_ready), 32'h0);
            chk("t4_no_consume", 32'(be_cnt), 32'h0);
        end
        drive(1'b1, 8'h11, 1'b1);
        chk("t4_handoff_cnt", 32'(be_cnt), 32'h1);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b0);
        chk("t4_next_word", be_a, 32'h1122_3344);
        drive(1'b0, 8'h00, 1'b1);

        // Timeout
        drive(1'b1, 8'h41, 1'b1);
        drive(1'b1, 8'h20, 1'b1);
        repeat (TMO - 1) drive(1'b0, 8'h00, 1'b1);
        chk("t5_pre_to", 32'(be_to), 32'h0);
        chk("t5_pre_cnt", 32'(be_cnt), 32'h2);
        drive(1'b0, 8'h00, 1'b1);
        chk("t5_to_pulse", 32'(be_to), 32'h1);
        chk("t5_cnt_clr", 32'(be_cnt), 32'h0);
        drive(1'b0, 8'h00, 1'b1);
        chk("t5_to_end", 32'(be_to), 32'h0);
        send4(32'h4000_0000, 1'b1);
        chk("t5_after", be_a, 32'h4000_0000);
        drive(1'b0, 8'h00, 1'b1);

        // Byte on the limit cycle wins over the timeout
        drive(1'b1, 8'h12, 1'b1);
        repeat (TMO - 1) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h34, 1'b1);
        chk("t6_no_to", 32'(be_to), 32'h0);
        chk("t6_cnt", 32'(be_cnt), 32'h2);
        drive(1'b1, 8'h56, 1'b1);
        drive(1'b1, 8'h78, 1'b1);
        chk("t6_word", be_a, 32'h1234_5678);
        drive(1'b0, 8'h00, 1'b1);

        // Reset during a partial word
        drive(1'b1, 8'h01, 1'b1);
        drive(1'b1, 8'h02, 1'b1);
        drive(1'b1, 8'h03, 1'b1);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        reset_checks("t7_reset");
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        chk("t7_no_to", 32'(be_to), 32'h0);
        send4(32'h0A0B_0C0D, 1'b1);
        chk("t7_fresh", be_a, 32'h0A0B_0C0D);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
